// File: rtl/nmi_rr_arbiter.sv
// rtl/nmi_rr_arbiter.sv - round-robin arbiter sharing one PicoRV32 NMI port among N masters
// Grants are registered; every transaction passes through IDLE so the bridge sees a fresh setup.
module nmi_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_MASTERS-1:0]          s_valid_i,
   output logic [N_MASTERS-1:0]          s_ready_o,
   input  logic [N_MASTERS*AW-1:0]       s_addr_i,
   input  logic [N_MASTERS*DW-1:0]       s_wdata_i,
   input  logic [N_MASTERS*(DW/8)-1:0]   s_wstrb_i,
   output logic [N_MASTERS*DW-1:0]       s_rdata_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic [AW-1:0]                 m_addr_o,
   output logic [DW-1:0]                 m_wdata_o,
   output logic [DW/8-1:0]               m_wstrb_o,
   input  logic [DW-1:0]                 m_rdata_i,
   output logic [GW-1:0]                 grant_o,
   output logic                          busy_o
);

   localparam int SW = DW / 8;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [GW-1:0]   r_ptr;
   logic [GW-1:0]   r_grant;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [SW-1:0]   r_wstrb;
   logic [GW-1:0]   w_win;
   logic            w_start;
   logic            w_done;

   assign w_start = (r_state == S_IDLE) && (|s_valid_i);
   assign w_done  = (r_state == S_BUSY) && m_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (|s_valid_i) w_state_nxt = S_BUSY;
         S_BUSY:  if (m_ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Scan from ptr+1 upward with wrap; the first active requester wins.
   always_comb begin : p_pick
      logic [GW:0] w_cand;
      logic        w_found;
      w_win   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         w_cand = {1'b0, r_ptr} + (GW+1)'(k + 1);
         if (w_cand >= (GW+1)'(N_MASTERS)) begin
            w_cand = w_cand - (GW+1)'(N_MASTERS);
         end
         if (!w_found && s_valid_i[w_cand[GW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_cand[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr   <= GW'(N_MASTERS - 1);
         r_grant <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_start) begin
         r_ptr   <= w_win;
         r_grant <= w_win;
         r_addr  <= s_addr_i[int'(w_win)*AW +: AW];
         r_wdata <= s_wdata_i[int'(w_win)*DW +: DW];
         r_wstrb <= s_wstrb_i[int'(w_win)*SW +: SW];
      end else if (w_done) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end
   end

   // The response goes to the granted slot even if that master already dropped valid.
   always_comb begin
      m_valid_o = (r_state == S_BUSY);
      busy_o    = (r_state == S_BUSY);
      m_addr_o  = r_addr;
      m_wdata_o = r_wdata;
      m_wstrb_o = r_wstrb;
      grant_o   = r_grant;
      s_ready_o = '0;
      s_rdata_o = '0;
      if (w_done) begin
         s_ready_o[r_grant]               = 1'b1;
         s_rdata_o[int'(r_grant)*DW +: DW] = m_rdata_i;
      end
   end

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// tb/tb_nmi_rr_arbiter.sv - directed self-checking bench for nmi_rr_arbiter
module tb_nmi_rr_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic [1:0]   v2;
   logic [1:0]   rdy2;
   logic [63:0]  addr2, wdata2, rdata2;
   logic [7:0]   wstrb2;
   logic         mvalid2, mready2, busy2;
   logic [31:0]  maddr2, mwdata2, mrdata2;
   logic [3:0]   mwstrb2;
   logic [0:0]   grant2;

   logic [3:0]   v4;
   logic [3:0]   rdy4;
   logic [127:0] addr4, wdata4, rdata4;
   logic [15:0]  wstrb4;
   logic         mvalid4, mready4, busy4;
   logic [31:0]  maddr4, mwdata4, mrdata4;
   logic [3:0]   mwstrb4;
   logic [1:0]   grant4;

   nmi_rr_arbiter #(.N_MASTERS(2), .AW(32), .DW(32)) dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .s_valid_i(v2), .s_ready_o(rdy2), .s_addr_i(addr2), .s_wdata_i(wdata2),
      .s_wstrb_i(wstrb2), .s_rdata_o(rdata2),
      .m_valid_o(mvalid2), .m_ready_i(mready2), .m_addr_o(maddr2), .m_wdata_o(mwdata2),
      .m_wstrb_o(mwstrb2), .m_rdata_i(mrdata2), .grant_o(grant2), .busy_o(busy2)
   );

   nmi_rr_arbiter #(.N_MASTERS(4), .AW(32), .DW(32)) dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .s_valid_i(v4), .s_ready_o(rdy4), .s_addr_i(addr4), .s_wdata_i(wdata4),
      .s_wstrb_i(wstrb4), .s_rdata_o(rdata4),
      .m_valid_o(mvalid4), .m_ready_i(mready4), .m_addr_o(maddr4), .m_wdata_o(mwdata4),
      .m_wstrb_o(mwstrb4), .m_rdata_i(mrdata4), .grant_o(grant4), .busy_o(busy4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      v2 = '0; addr2 = '0; wdata2 = '0; wstrb2 = '0; mready2 = 1'b0; mrdata2 = '0;
      v4 = '0; addr4 = '0; wdata4 = '0; wstrb4 = '0; mready4 = 1'b0; mrdata4 = '0;
      tick();
      tick();
      chk("rst_mvalid2", 128'(mvalid2), 128'd0);
      chk("rst_busy2", 128'(busy2), 128'd0);
      chk("rst_grant2", 128'(grant2), 128'd0);
      chk("rst_mvalid4", 128'(mvalid4), 128'd0);
      chk("rst_addr4", 128'(maddr4), 128'd0);
      rst_n = 1'b1;
      tick();

      // single read from m0
      addr2[31:0] = 32'h1000_0004;
      v2 = 2'b01;
      chk("t1_idle_mvalid", 128'(mvalid2), 128'd0);
      tick();
      chk("t1_mvalid", 128'(mvalid2), 128'd1);
      chk("t1_addr", 128'(maddr2), 128'h1000_0004);
      chk("t1_grant", 128'(grant2), 128'd0);
      chk("t1_rdy_wait", 128'(rdy2), 128'd0);
      mready2 = 1'b1; mrdata2 = 32'hDEAD_BEEF;
      #1;
      chk("t1_rdy", 128'(rdy2), 128'b01);
      chk("t1_rdata", 128'(rdata2), {96'd0, 64'h0000_0000_DEAD_BEEF} );
      tick();
      mready2 = 1'b0; mrdata2 = '0; v2 = 2'b00;
      chk("t1_after_mvalid", 128'(mvalid2), 128'd0);
      chk("t1_after_addr", 128'(maddr2), 128'd0);

      // alternating grants after reset
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      addr2 = {32'h2000_0010, 32'h1000_0020};
      v2 = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_mvalid", 128'(mvalid2), 128'd1);
         chk("t2_grant", 128'(grant2), 128'(i % 2));
         mready2 = 1'b1;
         #1;
         chk("t2_rdy", 128'(rdy2), 128'(2'b01 << (i % 2)));
         tick();
         mready2 = 1'b0;
         chk("t2_gap", 128'(mvalid2), 128'd0);
      end

      // write from m1 with delayed ready; m0 waits
      v2 = 2'b10;
      wdata2[63:32] = 32'h0000_A5A5;
      wstrb2[7:4] = 4'h3;
      tick();
      v2 = 2'b11;
      for (int i = 0; i < 5; i++) begin
         chk("t3_addr", 128'(maddr2), 128'h2000_0010);
         chk("t3_wdata", 128'(mwdata2), 128'h0000_A5A5);
         chk("t3_wstrb", 128'(mwstrb2), 128'h3);
         chk("t3_grant", 128'(grant2), 128'd1);
         chk("t3_rdy", 128'(rdy2), 128'd0);
         tick();
      end
      mready2 = 1'b1;
      tick();
      mready2 = 1'b0;
      v2 = 2'b01;
      chk("t3_gap", 128'(mvalid2), 128'd0);
      chk("t3_gap_wstrb", 128'(mwstrb2), 128'd0);
      tick();
      chk("t3_next_grant", 128'(grant2), 128'd0);
      chk("t3_next_addr", 128'(maddr2), 128'h1000_0020);
      mready2 = 1'b1;
      tick();
      mready2 = 1'b0;
      v2 = 2'b00;

      // m1 drops valid mid-transaction
      v2 = 2'b11;
      tick();
      chk("t6_grant", 128'(grant2), 128'd1);
      v2 = 2'b01;
      tick();
      chk("t6_hold_mvalid", 128'(mvalid2), 128'd1);
      chk("t6_hold_addr", 128'(maddr2), 128'h2000_0010);
      mready2 = 1'b1; mrdata2 = 32'h1234_5678;
      #1;
      chk("t6_rdy", 128'(rdy2), 128'b10);
      tick();
      mready2 = 1'b0; mrdata2 = '0;
      chk("t6_gap", 128'(mvalid2), 128'd0);
      tick();
      chk("t6_next_grant", 128'(grant2), 128'd0);
      chk("t6_next_mvalid", 128'(mvalid2), 128'd1);
      mready2 = 1'b1;
      tick();
      mready2 = 1'b0;
      v2 = 2'b00;

      // four masters: m3 then m1
      addr4[127:96] = 32'h3000_0000;
      addr4[63:32]  = 32'h1100_0000;
      v4 = 4'b1000;
      tick();
      chk("t4_grant3", 128'(grant4), 128'd3);
      chk("t4_addr3", 128'(maddr4), 128'h3000_0000);
      v4 = 4'b1010;
      mready4 = 1'b1;
      tick();
      mready4 = 1'b0;
      v4 = 4'b0010;
      chk("t4_gap", 128'(mvalid4), 128'd0);
      tick();
      chk("t4_grant1", 128'(grant4), 128'd1);
      chk("t4_addr1", 128'(maddr4), 128'h1100_0000);

      // reset while m1 is in flight
      mready4 = 1'b1;
      #1;
      chk("t5_rdy_pre", 128'(rdy4), 128'b0010);
      rst_n = 1'b0;
      #1;
      chk("t5_mvalid", 128'(mvalid4), 128'd0);
      chk("t5_busy", 128'(busy4), 128'd0);
      chk("t5_grant", 128'(grant4), 128'd0);
      chk("t5_addr", 128'(maddr4), 128'd0);
      chk("t5_rdy", 128'(rdy4), 128'd0);
      mready4 = 1'b0;
      addr4[95:64] = 32'h2200_0000;
      addr4[31:0]  = 32'h0000_0100;
      v4 = 4'b0101;
      #1;
      rst_n = 1'b1;
      tick();
      chk("t5_win0", 128'(grant4), 128'd0);
      chk("t5_win0_addr", 128'(maddr4), 128'h0000_0100);
      mready4 = 1'b1;
      tick();
      mready4 = 1'b0;
      v4 = 4'b0100;
      tick();
      chk("t5_then2", 128'(grant4), 128'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
